// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter: FSM states and owner identifiers.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StResp  = 2'd3
   } state_e;

   typedef enum logic {
      OwnIf = 1'b0,
      OwnD  = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between the fetch and memory stages,
// alternating grants on ties and squashing flushed fetch responses.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LAT    = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_flush,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic [DATA_W-1:0] o_if_rdata,
   output logic              o_if_valid,
   output logic              o_if_stall,
   input  logic              i_d_req,
   input  logic              i_d_wr,
   input  logic [ADDR_W-1:0] i_d_addr,
   input  logic [DATA_W-1:0] i_d_wdata,
   output logic [DATA_W-1:0] o_d_rdata,
   output logic              o_d_valid,
   output logic              o_d_stall,
   output logic              o_mem_en,
   output logic              o_mem_wr,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam int unsigned CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

   state_e            r_state, w_state_nxt;
   owner_e            r_owner, r_last, w_grant_owner;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_killed;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              w_if_req;
   logic              w_grant;
   logic              w_last_wait;

   // A fetch request seen together with flush is never granted.
   always_comb begin
      w_if_req      = i_if_req & ~i_flush;
      w_grant       = w_if_req | i_d_req;
      w_grant_owner = OwnIf;
      if (w_if_req && i_d_req) begin
         w_grant_owner = (r_last == OwnIf) ? OwnD : OwnIf;
      end else if (i_d_req) begin
         w_grant_owner = OwnD;
      end
   end

   assign w_last_wait = (r_cnt == CNT_W'(1));

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_grant) w_state_nxt = StIssue;
         StIssue: w_state_nxt = StWait;
         StWait:  if (w_last_wait) w_state_nxt = StResp;
         StResp:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_owner  <= OwnIf;
         r_last   <= OwnIf;
         r_cnt    <= '0;
         r_killed <= 1'b0;
         r_wr     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_grant) begin
                  r_owner <= w_grant_owner;
                  r_wr    <= (w_grant_owner == OwnD) ? i_d_wr : 1'b0;
                  r_addr  <= (w_grant_owner == OwnD) ? i_d_addr : i_if_addr;
                  r_wdata <= (w_grant_owner == OwnD) ? i_d_wdata : '0;
               end
            end
            StIssue: begin
               r_cnt <= LAT[CNT_W-1:0];
               if (i_flush && r_owner == OwnIf) r_killed <= 1'b1;
            end
            StWait: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (i_flush && r_owner == OwnIf) r_killed <= 1'b1;
               if (w_last_wait) r_rdata <= r_wr ? '0 : i_mem_rdata;
            end
            StResp: begin
               r_last   <= r_owner;
               r_killed <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign o_mem_en    = (r_state == StIssue);
   assign o_mem_wr    = (r_state == StIssue) & r_wr;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;

   assign o_d_valid   = (r_state == StResp) & (r_owner == OwnD);
   assign o_if_valid  = (r_state == StResp) & (r_owner == OwnIf) & ~r_killed & ~i_flush;
   assign o_if_rdata  = r_rdata;
   assign o_d_rdata   = r_rdata;

   assign o_if_stall  = i_if_req & ~o_if_valid & ~i_flush;
   assign o_d_stall   = i_d_req & ~o_d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural latency-2 memory and a response scoreboard.
module tb_mem_arbiter;

   typedef struct packed {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        if_req;
   logic [15:0] if_addr;
   logic [15:0] if_rdata;
   logic        if_valid;
   logic        if_stall;
   logic        d_req;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   logic        d_valid;
   logic        d_stall;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;
   int   c0;
   exp_t exp_if[$];
   exp_t exp_d[$];

   // Memory model: one remembered write, otherwise an address-derived pattern.
   logic        wr_v_m = 1'b0;
   logic [15:0] wr_a_m = '0;
   logic [15:0] wr_d_m = '0;
   logic [15:0] rd_p0  = '0;
   logic [15:0] rd_p1  = '0;

   mem_arbiter #(
      .ADDR_W (16),
      .DATA_W (16),
      .LAT    (2)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_flush     (flush),
      .i_if_req    (if_req),
      .i_if_addr   (if_addr),
      .o_if_rdata  (if_rdata),
      .o_if_valid  (if_valid),
      .o_if_stall  (if_stall),
      .i_d_req     (d_req),
      .i_d_wr      (d_wr),
      .i_d_addr    (d_addr),
      .i_d_wdata   (d_wdata),
      .o_d_rdata   (d_rdata),
      .o_d_valid   (d_valid),
      .o_d_stall   (d_stall),
      .o_mem_en    (mem_en),
      .o_mem_wr    (mem_wr),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata)
   );

   function automatic logic [15:0] dflt(input logic [15:0] a);
      return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hA5A5);
   endfunction

   function automatic logic [15:0] mem_read(input logic [15:0] a);
      return (wr_v_m && a == wr_a_m) ? wr_d_m : dflt(a);
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_en && mem_wr) begin
         wr_v_m <= 1'b1;
         wr_a_m <= mem_addr;
         wr_d_m <= mem_wdata;
      end
      rd_p0 <= (mem_en && !mem_wr) ? mem_read(mem_addr) : 16'hDEAD;
      rd_p1 <= rd_p0;
   end

   assign mem_rdata = rd_p1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (if_valid) begin
            if (exp_if.size() == 0) begin
               chk("if_valid_unexpected", 32'(if_valid), 0);
            end else begin
               e = exp_if.pop_front();
               chk("if_rdata", 32'(if_rdata), 32'(e.data));
               chk("if_valid_cycle", cyc, e.cyc);
            end
         end
         if (d_valid) begin
            if (exp_d.size() == 0) begin
               chk("d_valid_unexpected", 32'(d_valid), 0);
            end else begin
               e = exp_d.pop_front();
               chk("d_rdata", 32'(d_rdata), 32'(e.data));
               chk("d_valid_cycle", cyc, e.cyc);
            end
         end
      end
   endtask

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit is_if, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = is_if ? if_valid : d_valid;
      end
      if (!seen) chk(is_if ? "if_valid_timeout" : "d_valid_timeout", 32'(seen), 1);
      go();
      if (is_if) if_req = 1'b0;
      else d_req = 1'b0;
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_mem_en"}, 32'(mem_en), 0);
      chk({pfx, "_mem_wr"}, 32'(mem_wr), 0);
      chk({pfx, "_mem_addr"}, 32'(mem_addr), 0);
      chk({pfx, "_mem_wdata"}, 32'(mem_wdata), 0);
      chk({pfx, "_if_rdata"}, 32'(if_rdata), 0);
      chk({pfx, "_d_rdata"}, 32'(d_rdata), 0);
      chk({pfx, "_if_valid"}, 32'(if_valid), 0);
      chk({pfx, "_d_valid"}, 32'(d_valid), 0);
      chk({pfx, "_if_stall"}, 32'(if_stall), 0);
      chk({pfx, "_d_stall"}, 32'(d_stall), 0);
   endtask

   initial begin
      clk     = 1'b0;
      rst_n   = 1'b0;
      flush   = 1'b0;
      if_req  = 1'b0;
      if_addr = '0;
      d_req   = 1'b0;
      d_wr    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      fork
         forever #5 clk = ~clk;
         monitor();
      join_none

      // Reset values
      repeat (2) @(negedge clk);
      chk_zero("rst");
      go();
      rst_n = 1'b1;

      // Single fetch: mem_en in cycle 1, valid in cycle 4, stall in cycles 0-3
      go();
      c0 = cyc;
      if_req  = 1'b1;
      if_addr = 16'h0010;
      exp_if.push_back('{data: 16'hBEEF, cyc: c0 + 4});
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("f1_mem_en", 32'(mem_en), 32'(k == 1));
         chk("f1_if_stall", 32'(if_stall), 32'(k < 4));
         if (k == 1) begin
            chk("f1_mem_addr", 32'(mem_addr), 32'h0010);
            chk("f1_mem_wr", 32'(mem_wr), 0);
         end
      end
      go();
      if_req = 1'b0;

      // Tie with last=IF: data first, fetch after
      go();
      c0 = cyc;
      if_req  = 1'b1;
      if_addr = 16'h0020;
      d_req   = 1'b1;
      d_wr    = 1'b0;
      d_addr  = 16'h0100;
      exp_d.push_back('{data: dflt(16'h0100), cyc: c0 + 4});
      exp_if.push_back('{data: dflt(16'h0020), cyc: c0 + 9});
      @(negedge clk);
      go();
      @(negedge clk);
      chk("tie1_mem_addr", 32'(mem_addr), 32'h0100);
      wait_done(1'b0, 10);
      wait_done(1'b1, 10);

      // Data write
      go();
      c0 = cyc;
      d_req   = 1'b1;
      d_wr    = 1'b1;
      d_addr  = 16'h0200;
      d_wdata = 16'h1234;
      exp_d.push_back('{data: 16'h0000, cyc: c0 + 4});
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("wr_mem_en", 32'(mem_en), 32'(k == 1));
         chk("wr_mem_wr", 32'(mem_wr), 32'(k == 1));
         chk("wr_d_stall", 32'(d_stall), 1);
         if (k == 1) begin
            chk("wr_mem_addr", 32'(mem_addr), 32'h0200);
            chk("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
         end
      end
      wait_done(1'b0, 5);
      d_wr = 1'b0;

      // Tie with last=D: fetch first, reading back the write
      go();
      c0 = cyc;
      if_req  = 1'b1;
      if_addr = 16'h0200;
      d_req   = 1'b1;
      d_addr  = 16'h0010;
      exp_if.push_back('{data: 16'h1234, cyc: c0 + 4});
      exp_d.push_back('{data: 16'hBEEF, cyc: c0 + 9});
      wait_done(1'b1, 10);
      wait_done(1'b0, 10);

      // Flush in the WAIT of fetch 0x0030, then fetch 0x0034
      go();
      c0 = cyc;
      if_req  = 1'b1;
      if_addr = 16'h0030;
      go();
      go();
      flush = 1'b1;
      @(negedge clk);
      chk("fl_if_stall", 32'(if_stall), 0);
      go();
      flush   = 1'b0;
      if_addr = 16'h0034;
      exp_if.push_back('{data: dflt(16'h0034), cyc: c0 + 9});
      wait_done(1'b1, 12);

      // Flush in IDLE blocks the fetch grant; flush during a data read is ignored
      go();
      c0 = cyc;
      if_req  = 1'b1;
      if_addr = 16'h0040;
      flush   = 1'b1;
      @(negedge clk);
      chk("fd_if_stall", 32'(if_stall), 0);
      go();
      flush  = 1'b0;
      d_req  = 1'b1;
      d_addr = 16'h0300;
      exp_d.push_back('{data: dflt(16'h0300), cyc: c0 + 5});
      exp_if.push_back('{data: dflt(16'h0040), cyc: c0 + 10});
      @(negedge clk);
      chk("fd_no_grant", 32'(mem_en), 0);
      go();
      go();
      flush = 1'b1;
      @(negedge clk);
      chk("fd_d_stall", 32'(d_stall), 1);
      go();
      flush = 1'b0;
      wait_done(1'b0, 5);
      wait_done(1'b1, 10);

      // Reset in WAIT discards the response
      go();
      c0 = cyc;
      if_req  = 1'b1;
      if_addr = 16'h0050;
      go();
      go();
      @(negedge clk);
      rst_n  = 1'b0;
      if_req = 1'b0;
      #1;
      chk_zero("mid");
      go();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_mem_en", 32'(mem_en), 0);
      end
      go();
      c0 = cyc;
      if_req  = 1'b1;
      if_addr = 16'h0060;
      exp_if.push_back('{data: dflt(16'h0060), cyc: c0 + 4});
      wait_done(1'b1, 8);

      repeat (3) @(negedge clk);
      chk("if_sb_left", exp_if.size(), 0);
      chk("d_sb_left", exp_d.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported, fixed-latency memory (memory2c class) between the fetch stage and the memory stage of the pipeline. One access owns the memory at a time. Grants alternate when both stages request at once. The block returns read data and per-requester stall signals to the pipeline, and drops fetch responses when `flush` is asserted. It sits between the fetch/memory stages and the memory instance, which the parent instantiates.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `LAT`, 2, memory read latency in cycles after the `mem_en` cycle (≥1)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `flush`  in  1  squash in-flight or new fetch
- `if_req`  in  1  fetch read request, held until `if_valid`
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req`
- `if_rdata`  out  DATA_W  fetch read data
- `if_valid`  out  1  one-cycle completion pulse
- `if_stall`  out  1  fetch must hold
- `d_req`  in  1  data request, held until `d_valid`
- `d_wr`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_rdata`  out  DATA_W  data read result (0 for writes)
- `d_valid`  out  1  one-cycle completion pulse
- `d_stall`  out  1  memory stage must hold
- `mem_en`, `mem_wr`  out  1  memory strobe and write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  valid `LAT` cycles after `mem_en`

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **Registers:** `owner` (IF/D), `last` (last owner), `cnt`, `killed`, command latch (addr, wdata, wr), response data register.
- **IDLE:**
  - Grant the requester not equal to `last` if both request; otherwise grant whichever requests.
  - `if_req` is ignored in a cycle where `flush`=1.
  - On grant: latch the command, set `owner`, go to ISSUE.
  - No request: stay in IDLE.
- **ISSUE:** one cycle. `mem_en`=1; `mem_wr`, `mem_addr`, `mem_wdata` come from the latch. Load `cnt`=`LAT`, go to WAIT.
- **WAIT:** decrement `cnt` each cycle. In the cycle `cnt`==1, capture `mem_rdata` (0 if write) into the response register and go to RESP.
- **RESP:** one cycle.
  - `owner`=D: pulse `d_valid`.
  - `owner`=IF: pulse `if_valid` only if `killed`=0 and `flush`=0.
  - Set `last`=`owner`, clear `killed`, go to IDLE.
- **`killed`:** set by `flush` in ISSUE or WAIT when `owner`=IF. The memory access still completes; only the response is suppressed.
- **`flush` and data accesses:** `flush` never affects a data access.
- **Stall outputs (combinational):**
  - `if_stall` = `if_req` & ~`if_valid` & ~`flush`
  - `d_stall` = `d_req` & ~`d_valid`
- **Output data:** `if_rdata` and `d_rdata` both show the response register. They are meaningful only in the pulse cycle.
- **Outside ISSUE:** `mem_en`=0 and `mem_wr`=0.

## Timing
- **Reset values:**
  - State IDLE, `last`=IF (so data wins the first tie), `killed`=0, `cnt`=0.
  - All `*_valid`, `mem_en`, `mem_wr` = 0.
  - All data and address outputs = 0.
- **Latency:** request sampled in IDLE at cycle 0 → `mem_en` in cycle 1 → data captured at the end of cycle 1+`LAT` → valid in cycle 2+`LAT`. With `LAT`=2, valid arrives in cycle 4.
- **Throughput:** the requester drops or changes its request the cycle after valid. The next grant can occur in cycle 3+`LAT`, so one access completes per `LAT`+3 cycles.
- **Request stability:** a request deasserted before its grant is simply not served. Address and data are latched at grant, so changes after grant are ignored.
- **Reset mid-access:** immediate return to IDLE; the outstanding response is discarded with no valid pulse.
- **`flush` in the RESP cycle of a fetch:** suppresses that cycle's `if_valid`.
- **`flush` while data owns the memory:** no effect on the data access. A pending `if_req` is still served later if it persists after `flush` drops.

## Structure
- **Shared package/include `mem_arb_defs`:** state encodings (2-bit IDLE=0, ISSUE=1, WAIT=2, RESP=3), owner constants (`OWN_IF`=0, `OWN_D`=1).
- **Sub-modules:** none required. The FSM, counter and latches fit in one module of roughly 150–200 lines. The memory instance stays in the parent.

## Test plan
- **Reset values:** `rst`=0 mid-WAIT → all outputs 0, state IDLE; after release with no request, `mem_en` stays 0.
- **Single fetch:** `if_req`=1, `if_addr`=0x0010, memory returns 0xBEEF at `LAT`=2 → `mem_en` in cycle 1, `if_valid`=1 with `if_rdata`=0xBEEF in cycle 4, `if_stall`=1 in cycles 0–3.
- **Simultaneous requests:** fetch 0x0020 and data read 0x0100, both from reset → data served first (`d_valid` cycle 4), then fetch (`if_valid` cycle 9). A repeated tie alternates.
- **Data write:** `d_wr`=1, `d_addr`=0x0200, `d_wdata`=0x1234 → one-cycle `mem_en`=`mem_wr`=1 with that address and data; `d_valid` in cycle 4 with `d_rdata`=0.
- **Flush during fetch:** `flush` pulsed in the WAIT of fetch 0x0030 → no `if_valid`, state returns to IDLE, and the next fetch 0x0034 completes normally.
- **Flush during data access:** `flush` during a data read → `d_valid` is delivered unchanged, and `if_req` is not granted in the flush cycle.
